// File: rtl/frankie_control_if.sv
// frankie_control_if: control/status bundle between the Frankie control FSM and its datapath
interface frankie_control_if #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
);
    logic [OPW-1:0]   opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       addr_src;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             reg_write;
    logic [1:0]       reg_src;
    logic             ra_write;
    logic             swap_en;
    logic             sp_inc;
    logic             sp_dec;
    logic             halted;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, addr_src, alu_src_b, alu_op,
               reg_write, reg_src, ra_write, swap_en, sp_inc, sp_dec, halted, state, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, addr_src, alu_src_b, alu_op,
               reg_write, reg_src, ra_write, swap_en, sp_inc, sp_dec, halted, state, retired
    );
endinterface

// File: rtl/frankie_control.sv
// frankie_control: multi-cycle fetch/decode/execute/memory/writeback sequencer for the Frankie datapath
module frankie_control #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input logic               clock,
    input logic               reset,
    frankie_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        ALU_WB = 4'd3,
        LI_WB  = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        MEM_WB = 4'd7,
        JUMP   = 4'd8,
        BRANCH = 4'd9,
        SWAP   = 4'd10,
        HALT   = 4'd15
    } state_t;

    state_t           state_q, nxt;
    logic [OPW-1:0]   op;
    logic [CNT_W-1:0] retired;

    assign bus.state   = state_q;
    assign bus.retired = retired;

    // Next state and control outputs; everything forced low while reset is held
    always_comb begin
        nxt           = state_q;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 2'd0;
        bus.ir_write  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr_src  = 2'd0;
        bus.alu_src_b = 2'd0;
        bus.alu_op    = 3'd0;
        bus.reg_write = 1'b0;
        bus.reg_src   = 2'd0;
        bus.ra_write  = 1'b0;
        bus.swap_en   = 1'b0;
        bus.sp_inc    = 1'b0;
        bus.sp_dec    = 1'b0;
        bus.halted    = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.pc_write = bus.mem_ready;
                    nxt          = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.ir_write = 1'b1;
                    case (bus.opcode)
                        OPW'(0):                                                 nxt = LI_WB;
                        OPW'(1), OPW'(2), OPW'(3), OPW'(4), OPW'(5), OPW'(7), OPW'(8): nxt = EXEC;
                        OPW'(6):                                                 nxt = MEM_RD;
                        OPW'(9), OPW'(10):                                       nxt = JUMP;
                        OPW'(11):                                                nxt = SWAP;
                        OPW'(12):                                                nxt = BRANCH;
                        OPW'(15):                                                nxt = HALT;
                        default:                                                 nxt = FETCH;
                    endcase
                end
                EXEC: begin
                    case (op)
                        OPW'(1): nxt = ALU_WB;
                        OPW'(2): begin bus.alu_src_b = 2'd1; nxt = ALU_WB; end
                        OPW'(3): begin bus.alu_op = 3'd1; nxt = ALU_WB; end
                        OPW'(4): begin bus.alu_op = 3'd2; bus.alu_src_b = 2'd2; nxt = ALU_WB; end
                        OPW'(5): begin bus.sp_dec = 1'b1; nxt = MEM_WR; end
                        OPW'(7): begin bus.alu_src_b = 2'd1; nxt = MEM_RD; end
                        OPW'(8): begin bus.alu_src_b = 2'd1; nxt = MEM_WR; end
                        default: nxt = FETCH;
                    endcase
                end
                ALU_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_src   = 2'd1;
                    nxt           = FETCH;
                end
                LI_WB: begin
                    bus.reg_write = 1'b1;
                    nxt           = FETCH;
                end
                MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.addr_src = (op == OPW'(6)) ? 2'd2 : 2'd1;
                    nxt          = bus.mem_ready ? MEM_WB : MEM_RD;
                end
                MEM_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_src   = 2'd2;
                    bus.sp_inc    = (op == OPW'(6));
                    nxt           = FETCH;
                end
                MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.addr_src  = (op == OPW'(5)) ? 2'd2 : 2'd1;
                    nxt           = bus.mem_ready ? FETCH : MEM_WR;
                end
                JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = (op == OPW'(9)) ? 2'd1 : 2'd2;
                    bus.ra_write = (op == OPW'(9));
                    nxt          = FETCH;
                end
                BRANCH: begin
                    bus.pc_write = bus.zero;
                    bus.pc_src   = 2'd1;
                    nxt          = FETCH;
                end
                SWAP: begin
                    bus.swap_en = 1'b1;
                    nxt         = FETCH;
                end
                HALT:    bus.halted = 1'b1;
                default: nxt = FETCH;
            endcase
        end
    end

    // State register, decode-time opcode latch and retired-instruction counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            op      <= '0;
            retired <= '0;
        end else begin
            state_q <= nxt;
            if (state_q == DECODE) op <= bus.opcode;
            if ((nxt == FETCH || nxt == HALT) && nxt != state_q) retired <= retired + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_frankie_control.sv
// tb_frankie_control: directed vector table plus stall/halt/reset sequences for frankie_control
module tb_frankie_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frankie_control_if #(.OPW(4), .CNT_W(16)) b();
    frankie_control #(.OPW(4), .CNT_W(16)) dut (.clock(clk), .reset(rst), .bus(b));

    typedef struct {
        logic        r;
        logic [3:0]  opc;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ret;
        logic [20:0] ctl;
    } vec_t;

    vec_t        v[$];
    int          tests = 0;
    int          fails = 0;
    int          cnt_rd, cnt_pw;
    logic [20:0] act, fc, dc, nc, liw, awb, exb1;

    assign act = {b.pc_write, b.pc_src, b.ir_write, b.mem_read, b.mem_write, b.addr_src, b.alu_src_b,
                  b.alu_op, b.reg_write, b.reg_src, b.ra_write, b.swap_en, b.sp_inc, b.sp_dec, b.halted};

    // Packs expected controls in the same order as act; m = {ra_write, swap_en, sp_inc, sp_dec}
    function automatic logic [20:0] c(input int pw, ps, irw, mr, mw, asrc, bs, ao, rw, rs, m, h);
        return {1'(pw), 2'(ps), 1'(irw), 1'(mr), 1'(mw), 2'(asrc), 2'(bs), 3'(ao), 1'(rw), 2'(rs), 4'(m), 1'(h)};
    endfunction

    task automatic add(input int r, opc, z, rdy, st, ret, input logic [20:0] ctl);
        vec_t t;
        t.r   = 1'(r);
        t.opc = 4'(opc);
        t.z   = 1'(z);
        t.rdy = 1'(rdy);
        t.st  = 4'(st);
        t.ret = 16'(ret);
        t.ctl = ctl;
        v.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        b.mem_ready = 1'b0;
        b.opcode    = 4'd0;
        b.zero      = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        fc   = c(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        dc   = c(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nc   = '0;
        liw  = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        awb  = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        exb1 = c(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // reset, then LI / ADDI / LI / ADD trace
        add(1, 15, 0, 1, 0, 0, nc);
        add(0, 15, 0, 1, 0, 0, fc);  add(0, 0, 0, 1, 1, 0, dc);  add(0, 15, 0, 1, 4, 0, liw);
        add(0, 15, 0, 1, 0, 1, fc);  add(0, 2, 0, 1, 1, 1, dc);  add(0, 15, 0, 1, 2, 1, exb1);
        add(0, 15, 0, 1, 3, 1, awb);
        add(0, 15, 0, 1, 0, 2, fc);  add(0, 0, 0, 1, 1, 2, dc);  add(0, 15, 0, 1, 4, 2, liw);
        add(0, 15, 0, 1, 0, 3, fc);  add(0, 1, 0, 1, 1, 3, dc);  add(0, 15, 0, 1, 2, 3, nc);
        add(0, 15, 0, 1, 3, 3, awb);
        // SUB, LBI
        add(0, 15, 0, 1, 0, 4, fc);  add(0, 3, 0, 1, 1, 4, dc);
        add(0, 15, 0, 1, 2, 4, c(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));  add(0, 15, 0, 1, 3, 4, awb);
        add(0, 15, 0, 1, 0, 5, fc);  add(0, 4, 0, 1, 1, 5, dc);
        add(0, 15, 0, 1, 2, 5, c(0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0));  add(0, 15, 0, 1, 3, 5, awb);
        // LW, SW
        add(0, 15, 0, 1, 0, 6, fc);  add(0, 7, 0, 1, 1, 6, dc);  add(0, 15, 0, 1, 2, 6, exb1);
        add(0, 15, 0, 1, 5, 6, c(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        add(0, 15, 0, 1, 7, 6, c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        add(0, 15, 0, 1, 0, 7, fc);  add(0, 8, 0, 1, 1, 7, dc);  add(0, 15, 0, 1, 2, 7, exb1);
        add(0, 15, 0, 1, 6, 7, c(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // PUSH, POP
        add(0, 15, 0, 1, 0, 8, fc);  add(0, 5, 0, 1, 1, 8, dc);
        add(0, 15, 0, 1, 2, 8, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(0, 15, 0, 1, 6, 8, c(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
        add(0, 15, 0, 1, 0, 9, fc);  add(0, 6, 0, 1, 1, 9, dc);
        add(0, 15, 0, 1, 5, 9, c(0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        add(0, 15, 0, 1, 7, 9, c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0));
        // JAL, RET, SWAP
        add(0, 15, 0, 1, 0, 10, fc); add(0, 9, 0, 1, 1, 10, dc);
        add(0, 15, 0, 1, 8, 10, c(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        add(0, 15, 0, 1, 0, 11, fc); add(0, 10, 0, 1, 1, 11, dc);
        add(0, 15, 0, 1, 8, 11, c(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 15, 0, 1, 0, 12, fc); add(0, 11, 0, 1, 1, 12, dc);
        add(0, 15, 0, 1, 10, 12, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0));
        // BEQ taken, BEQ not taken, reserved NOP
        add(0, 15, 0, 1, 0, 13, fc); add(0, 12, 1, 1, 1, 13, dc);
        add(0, 15, 1, 1, 9, 13, c(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 15, 0, 1, 0, 14, fc); add(0, 12, 0, 1, 1, 14, dc);
        add(0, 15, 0, 1, 9, 14, c(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 15, 0, 1, 0, 15, fc); add(0, 13, 0, 1, 1, 15, dc);
        add(0, 15, 0, 1, 0, 16, fc);

        b.opcode    = 4'd0;
        b.zero      = 1'b0;
        b.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        foreach (v[i]) begin
            rst         = v[i].r;
            b.opcode    = v[i].opc;
            b.zero      = v[i].z;
            b.mem_ready = v[i].rdy;
            #1;
            chk($sformatf("row%0d state", i), 32'(b.state), 32'(v[i].st));
            chk($sformatf("row%0d ctl", i), 32'(act), 32'(v[i].ctl));
            chk($sformatf("row%0d retired", i), 32'(b.retired), 32'(v[i].ret));
            tick();
        end

        // fetch stalled three cycles on mem_ready
        do_reset();
        cnt_rd = 0;
        cnt_pw = 0;
        for (int k = 0; k < 4; k++) begin
            b.mem_ready = (k == 3);
            #1;
            chk($sformatf("stall%0d state", k), 32'(b.state), 32'd0);
            chk($sformatf("stall%0d ctl", k), 32'(act), (k == 3) ? 32'(fc) : 32'(c(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
            cnt_rd += int'(b.mem_read);
            cnt_pw += int'(b.pc_write);
            tick();
        end
        chk("stall mem_read cycles", 32'(cnt_rd), 32'd4);
        chk("stall pc_write count", 32'(cnt_pw), 32'd1);
        chk("stall then decode", 32'(b.state), 32'd1);

        // HALT from decode: sticky, no strobes, counted once
        b.opcode = 4'hF;
        tick();
        b.opcode = 4'h0;
        for (int k = 0; k < 10; k++) begin
            b.mem_ready = k[0];
            b.zero      = k[1];
            #1;
            chk($sformatf("halt%0d state", k), 32'(b.state), 32'd15);
            chk($sformatf("halt%0d ctl", k), 32'(act), 32'(c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
            chk($sformatf("halt%0d retired", k), 32'(b.retired), 32'd1);
            tick();
        end

        // reset while an SW is stalled in MEM_WR
        do_reset();
        b.mem_ready = 1'b1;
        tick();
        b.opcode = 4'hD;
        tick();
        tick();
        b.opcode = 4'h8;
        tick();
        b.opcode = 4'h0;
        tick();
        b.mem_ready = 1'b0;
        #1;
        chk("sw stall state", 32'(b.state), 32'd6);
        chk("sw stall ctl", 32'(act), 32'(c(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)));
        chk("sw stall retired", 32'(b.retired), 32'd1);
        tick();
        chk("sw still stalled", 32'(b.state), 32'd6);
        rst = 1'b1;
        #1;
        chk("reset gates mem_write", 32'(b.mem_write), 32'd0);
        tick();
        chk("post reset state", 32'(b.state), 32'd0);
        chk("post reset mem_write", 32'(b.mem_write), 32'd0);
        chk("post reset retired", 32'(b.retired), 32'd0);
        rst = 1'b0;
        #1;
        chk("after reset ctl", 32'(act), 32'(c(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tick();
        chk("after reset hold fetch", 32'(b.state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
